alu_div_iter: RTL and testbench
===============================

# alu_div_iter

Iterative 32-bit integer divide/remainder unit for the EX stage. It takes the same two operands that the ALU's compare, add and SLT paths receive from the ID/EX register. Its registered result goes to the same EX result mux the ALU output feeds. It implements RV32M DIV/DIVU/REM/REMU with a radix-2 restoring algorithm: one subtract-and-compare step per cycle on a 33-bit partial remainder. A start/busy/valid handshake lets the hazard unit stall the pipeline while a divide is in flight.

## Interface
- WIDTH, 32, operand and result width; only 32 is supported.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  request a divide; sampled only when o_busy=0.
- i_op  in  2  00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
- i_div_a  in  32  dividend.
- i_div_b  in  32  divisor.
- o_busy  out  1  operation in flight; new starts are ignored.
- o_valid  out  1  one-cycle pulse; o_div_result is valid in this cycle.
- o_div_result  out  32  quotient or remainder; holds its value until the next completion.

## Operation
- FSM states: IDLE, CALC, FIX.
  - IDLE: on an edge with i_start=1, latch op, operand signs, magnitudes and special-case flags.
    - Special case: go to FIX directly.
    - Otherwise: go to CALC with count=0.
  - CALC: 32 iterations, count 0..31. Then go to FIX.
  - FIX: register the final result, pulse o_valid, return to IDLE.
- Magnitudes:
  - Signed ops (DIV, REM): |a| and |b| as unsigned 32-bit values. |0x80000000| = 0x80000000.
  - Unsigned ops: raw operands.
- Iteration, MSB of dividend first:
  - rem33 = {rem[31:0], dvd[31]}; dvd shifts left.
  - trial = rem33 + ~{1'b0, divisor} + 1.
  - If trial[32]=0 (no borrow): rem = trial[31:0] and shift in quotient bit 1.
  - Else: keep rem33[31:0] and shift in quotient bit 0.
- Sign fix in FIX:
  - Quotient is negated when the op is signed and sign(a) != sign(b).
  - Remainder is negated when the op is signed and sign(a)=1.
  - The result is the quotient for ops 00/01 and the remainder for ops 10/11.
- Special cases, detected at start, bypass CALC:
  - Divisor = 0: quotient = 0xFFFFFFFF for both DIV and DIVU; remainder = a.
  - Signed overflow, DIV or REM with a=0x80000000 and b=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Operands are latched at start. Later changes to i_div_a, i_div_b or i_op have no effect.
- i_start while o_busy=1 is ignored; nothing is queued.
- All arithmetic is modulo 2^32, except the 33-bit trial subtract.

## Timing
- Reset values: state IDLE, o_busy=0, o_valid=0, o_div_result=0x00000000, count=0.
- Reset asserted mid-operation aborts immediately:
  - o_busy and o_valid drop asynchronously.
  - No stale o_valid is produced after reset is released.
- Normal op, start accepted on edge k:
  - o_busy=1 from edge k until edge k+33.
  - CALC occupies edges k+1..k+32.
  - The FIX edge k+33 registers the result. o_valid=1 and o_busy=0 for the cycle after edge k+33.
  - Latency is 33 cycles from the start edge to the valid cycle.
- Special case, start on edge k: the result is registered on edge k+1. o_valid=1 and o_busy=0 for that one cycle; o_busy=1 only for the cycle between k and k+1.
- o_valid is never high for two consecutive cycles unless two operations complete back to back.
- Back-to-back: i_start=1 during the o_valid cycle is accepted on the next edge. o_valid then drops and o_busy rises.
- o_busy is a registered output with no combinational path from i_start.

## Test plan
- DIVU 100/7: start at edge k. o_busy=1 for 33 cycles, then a single o_valid pulse with o_div_result=0x0000000E. REMU with the same operands gives 0x00000002.
- Signed ops:
  - DIV 0xFFFFFFF9(-7)/2 → 0xFFFFFFFD.
  - REM -7/2 → 0xFFFFFFFF.
  - DIV 7/0xFFFFFFFE(-2) → 0xFFFFFFFD.
  - REM 7/-2 → 0x00000001.
  - DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- Divide by zero:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 0x12345678/0 → 0x12345678.
  - o_valid appears one cycle after the start edge.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0x00000000; both take the fast path.
- Handshake:
  - i_start pulsed and operands changed mid-CALC → ignored; the original result is unchanged.
  - i_start in the o_valid cycle → a second op starts and completes 33 cycles later with a correct result.
- Reset: assert i_rst_n=0 at iteration 10, release after 2 cycles. o_busy=0, o_valid=0 and o_div_result=0 immediately, and no o_valid pulse occurs afterwards without a new i_start.

Source files
------------

// File: rtl/alu_div_iter_if.sv
// Start/busy/valid handshake bundle for the iterative divide unit.
// master drives requests (EX control), slave is the divider.
interface alu_div_iter_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic [1:0]       i_op;
    logic [WIDTH-1:0] i_div_a;
    logic [WIDTH-1:0] i_div_b;
    logic             o_busy;
    logic             o_valid;
    logic [WIDTH-1:0] o_div_result;

    modport master (
        output i_start,
        output i_op,
        output i_div_a,
        output i_div_b,
        input  o_busy,
        input  o_valid,
        input  o_div_result
    );

    modport slave (
        input  i_start,
        input  i_op,
        input  i_div_a,
        input  i_div_b,
        output o_busy,
        output o_valid,
        output o_div_result
    );
endinterface

// File: rtl/alu_div_iter.sv
// RV32M DIV/DIVU/REM/REMU, radix-2 restoring, one quotient bit per cycle.
// Divide-by-zero and signed overflow skip straight to the result stage.
module alu_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    alu_div_iter_if.slave div_if
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sel_rem_q, sel_rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] res_q, res_d;

    logic             op_signed;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             div_zero;
    logic             ovf;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign op_signed = ~div_if.i_op[0];
    assign sign_a    = op_signed & div_if.i_div_a[WIDTH-1];
    assign sign_b    = op_signed & div_if.i_div_b[WIDTH-1];
    assign mag_a     = sign_a ? -div_if.i_div_a : div_if.i_div_a;
    assign mag_b     = sign_b ? -div_if.i_div_b : div_if.i_div_b;
    assign div_zero  = (div_if.i_div_b == '0);
    assign ovf       = op_signed & (div_if.i_div_a == MIN_NEG)
                     & (div_if.i_div_b == '1);

    // Partial remainder shifted left with the next dividend bit, minus divisor
    assign trial = {rem_q, dvd_q[WIDTH-1]} + ~{1'b0, dvs_q}
                 + {{WIDTH{1'b0}}, 1'b1};

    assign quo_fix = neg_quo_q ? -dvd_q : dvd_q;
    assign rem_fix = neg_rem_q ? -rem_q : rem_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        sel_rem_d = sel_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        res_d     = res_q;

        unique case (state_q)
            IDLE: begin
                if (div_if.i_start) begin
                    sel_rem_d = div_if.i_op[1];
                    busy_d    = 1'b1;
                    if (div_zero || ovf) begin
                        // Preload final quotient/remainder; no sign fix needed
                        state_d   = FIX;
                        rem_d     = div_zero ? div_if.i_div_a : '0;
                        dvd_d     = div_zero ? '1 : MIN_NEG;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                    end else begin
                        state_d   = CALC;
                        count_d   = '0;
                        rem_d     = '0;
                        dvd_d     = mag_a;
                        dvs_d     = mag_b;
                        neg_quo_d = sign_a ^ sign_b;
                        neg_rem_d = sign_a;
                    end
                end
            end
            CALC: begin
                rem_d   = trial[WIDTH] ? {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]}
                                       : trial[WIDTH-1:0];
                // Quotient bits fill the dividend register from the LSB
                dvd_d   = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                res_d   = sel_rem_q ? rem_fix : quo_fix;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            sel_rem_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            sel_rem_q <= sel_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            res_q     <= res_d;
        end
    end

    assign div_if.o_busy       = busy_q;
    assign div_if.o_valid      = valid_q;
    assign div_if.o_div_result = res_q;
endmodule

// File: tb/tb_alu_div_iter.sv
// Directed and random bench for alu_div_iter against an arithmetic model.
// Checks result, latency, busy/valid handshake, and reset abort.
module tb_alu_div_iter;
    logic clk;
    logic rst_n;
    int   vecs;
    int   miss;

    alu_div_iter_if #(.WIDTH(32)) dif ();

    alu_div_iter #(.WIDTH(32)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .div_if (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(
        input logic [1:0] op, input logic [31:0] a, input logic [31:0] b
    );
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : 32'h8000_0000;
        case (op)
            2'd0:    return sa / sb;
            2'd1:    return a / b;
            2'd2:    return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int exp_lat(
        input logic [1:0] op, input logic [31:0] a, input logic [31:0] b
    );
        if (b == 32'h0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; start is taken on the following posedge
    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        dif.i_start = 1'b1;
        dif.i_op    = op;
        dif.i_div_a = a;
        dif.i_div_b = b;
        @(posedge clk);
        #1;
        dif.i_start = 1'b0;
        dif.i_op    = 2'($urandom);
        dif.i_div_a = $urandom;
        dif.i_div_b = $urandom;
    endtask

    // Returns at the negedge of the valid cycle (or on timeout)
    task automatic wait_done(input string tag, input logic [31:0] exp,
                             input int lat, input bit poke);
        int n;
        n = 1;
        @(negedge clk);
        chk({tag, ".busy"}, 32'(dif.o_busy), 32'd1);
        while (!dif.o_valid && n < 40) begin
            if (poke && n == 10) begin
                dif.i_start = 1'b1;
                dif.i_op    = 2'($urandom);
                dif.i_div_a = $urandom;
                dif.i_div_b = $urandom;
            end else begin
                dif.i_start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        dif.i_start = 1'b0;
        chk({tag, ".valid"}, 32'(dif.o_valid), 32'd1);
        chk({tag, ".lat"}, 32'(n - 1), 32'(lat));
        chk({tag, ".busy_done"}, 32'(dif.o_busy), 32'd0);
        chk({tag, ".res"}, dif.o_div_result, exp);
    endtask

    task automatic run(input string tag, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit poke);
        issue(op, a, b);
        wait_done(tag, exp, exp_lat(op, a, b), poke);
        @(negedge clk);
        chk({tag, ".vdrop"}, 32'(dif.o_valid), 32'd0);
        chk({tag, ".hold"}, dif.o_div_result, exp);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          pulses;
        vecs        = 0;
        miss        = 0;
        rst_n       = 1'b0;
        dif.i_start = 1'b0;
        dif.i_op    = 2'd0;
        dif.i_div_a = 32'h0;
        dif.i_div_b = 32'h0;
        #3;
        chk("rst.busy", 32'(dif.o_busy), 32'd0);
        chk("rst.valid", 32'(dif.o_valid), 32'd0);
        chk("rst.res", dif.o_div_result, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run("divu100_7", 2'd1, 32'd100, 32'd7, 32'h0000_000E, 1'b0);
        run("remu100_7", 2'd3, 32'd100, 32'd7, 32'h0000_0002, 1'b0);
        run("div-7_2", 2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        run("rem-7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        run("div7_-2", 2'd0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        run("rem7_-2", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run("divu_big", 2'd1, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1'b0);
        run("div5_0", 2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
        run("remu_0", 2'd3, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0);
        run("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h8000_0000, 1'b0);
        run("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
        run("divu_min", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
        run("poke", 2'd1, 32'd100, 32'd7, 32'h0000_000E, 1'b1);

        issue(2'd0, 32'hFFFF_FFF9, 32'd2);
        wait_done("b2b1", 32'hFFFF_FFFD, 33, 1'b0);
        issue(2'd2, 32'd7, 32'hFFFF_FFFE);
        wait_done("b2b2", 32'h0000_0001, 33, 1'b0);
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: b = b >> $urandom_range(1, 31);
                4: a = $urandom_range(0, 255);
                default: ;
            endcase
            run($sformatf("rnd%0d", i), op, a, b, model(op, a, b), 1'b0);
        end

        issue(2'd1, 32'hDEAD_BEEF, 32'd3);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.busy", 32'(dif.o_busy), 32'd0);
        chk("abort.valid", 32'(dif.o_valid), 32'd0);
        chk("abort.res", dif.o_div_result, 32'h0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dif.o_valid || dif.o_busy) pulses++;
        end
        chk("abort.quiet", 32'(pulses), 32'd0);
        chk("abort.res_hold", dif.o_div_result, 32'h0);

        run("after_rst", 2'd0, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
